seg7_scan_decoder: RTL and testbench

Recovers BCD digit values from a multiplexed 7-segment display bus, the inverse of the BCD-to-7-segment encoder path. It sits on the clock's display outputs, or on an external display bus, as a self-check and readback monitor. Per digit, it waits for select and segment lines to stay stable, decodes the glyph to BCD and stores it. It reports a full frame once every digit has been captured.

---
 rtl/seg7_scan_decoder.sv | 145 ++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed 7-segment bus: waits for a stable select/segment pair,
// decodes the glyph to BCD per digit and pulses once per complete frame.
// Optional feature: define SEG7_ALT_GLYPH_EN to accept alternate 6/7/9 glyphs.
module seg7_scan_decoder #(
  parameter int unsigned NUM_DIGITS    = 6,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic [NUM_DIGITS-1:0]     i_digit_sel,
  input  logic [6:0]                i_led,
  output logic [4*NUM_DIGITS-1:0]   o_bcd,
  output logic [NUM_DIGITS-1:0]     o_digit_err,
  output logic                      o_frame_valid,
  output logic                      o_frame_err
);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);
  localparam logic [7:0] CntCap = 8'(STABLE_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [NUM_DIGITS-1:0]     sel_q;
  logic [6:0]                led_q;
  logic [7:0]                cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]     bitmap_q, bitmap_d;
  logic [4*NUM_DIGITS-1:0]   bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]     digit_err_q, digit_err_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      same, raw_onehot, capture;
  logic [4:0]                glyph;

  // Returns {err, bcd}.
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    logic [4:0] r;
    case (seg)
      7'b1111110: r = 5'h00;
      7'b0110000: r = 5'h01;
      7'b1101101: r = 5'h02;
      7'b1111001: r = 5'h03;
      7'b0110011: r = 5'h04;
      7'b1011011: r = 5'h05;
      7'b1011111: r = 5'h06;
      7'b1110000: r = 5'h07;
      7'b1111111: r = 5'h08;
      7'b1111011: r = 5'h09;
`ifdef SEG7_ALT_GLYPH_EN
      7'b0011111: r = 5'h06;
      7'b1110011: r = 5'h09;
      7'b1110010: r = 5'h07;
`endif
      7'b0000000: r = 5'h0F;
      default:    r = 5'h1E;
    endcase
    return r;
  endfunction

  assign same       = (i_digit_sel == sel_q) && (i_led == led_q);
  assign raw_onehot = (i_digit_sel != '0) && ((i_digit_sel & (i_digit_sel - 1'b1)) == '0);
  assign glyph      = decode_glyph(led_q);

  // The FSM tracks the sample being registered this edge, so a new pair starts counting at once.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (!same || !raw_onehot) begin
      cnt_d = 8'd0;
    end else if (cnt_q < CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    unique case (state_q)
      StIdle: begin
        if (raw_onehot) state_d = StSettle;
      end
      StSettle: begin
        if (!same) begin
          state_d = raw_onehot ? StSettle : StIdle;
        end else if (cnt_q == CntCap) begin
          capture = 1'b1;
          state_d = StHeld;
        end
      end
      StHeld: begin
        if (!same) state_d = raw_onehot ? StSettle : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bcd_d         = bcd_q;
    digit_err_d   = digit_err_q;
    bitmap_d      = bitmap_q;
    frame_valid_d = 1'b0;
    frame_err_d   = 1'b0;
    if (capture) begin
      for (int n = 0; n < int'(NUM_DIGITS); n++) begin
        if (sel_q[n]) begin
          bcd_d[4*n +: 4] = glyph[3:0];
          digit_err_d[n]  = glyph[4];
        end
      end
      bitmap_d = bitmap_q | sel_q;
      if (&bitmap_d) begin
        frame_valid_d = 1'b1;
        frame_err_d   = |digit_err_d;
        bitmap_d      = '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= StIdle;
      sel_q         <= '0;
      led_q         <= '0;
      cnt_q         <= 8'd0;
      bitmap_q      <= '0;
      bcd_q         <= {NUM_DIGITS{4'hF}};
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_q         <= i_digit_sel;
      led_q         <= i_led;
      cnt_q         <= cnt_d;
      bitmap_q      <= bitmap_d;
      bcd_q         <= bcd_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
    end
  end

  assign o_bcd         = bcd_q;
  assign o_digit_err   = digit_err_q;
  assign o_frame_valid = frame_valid_q;
  assign o_frame_err   = frame_err_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scenarios plus random dwell sequences, all checked
// against a run-length reference model of the capture rules.
module tb_seg7_scan_decoder;
  localparam int unsigned ND = 6;
  localparam int unsigned SC = 4;
  localparam logic [6:0] GLYPH [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                        7'b1111111, 7'b1111011};

  logic            clk = 1'b0;
  logic            rst;
  logic [ND-1:0]   sel;
  logic [6:0]      led;
  logic [4*ND-1:0] bcd;
  logic [ND-1:0]   digit_err;
  logic            frame_valid, frame_err;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .i_clk(clk), .i_reset(rst), .i_digit_sel(sel), .i_led(led),
    .o_bcd(bcd), .o_digit_err(digit_err), .o_frame_valid(frame_valid), .o_frame_err(frame_err)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: a pair is captured once it has been present on SC+1 consecutive edges.
  logic [4*ND-1:0] m_bcd;
  logic [ND-1:0]   m_err, m_map, m_last_sel;
  logic [6:0]      m_last_led;
  logic            m_fv, m_fe;
  int              run = 0;
  int              pulses, pulse_at, edge_in_seg;
  logic            last_fe;

  function automatic logic [4:0] ref_decode(input logic [6:0] g);
    for (int i = 0; i < 10; i++) if (g == GLYPH[i]) return {1'b0, 4'(i)};
`ifdef SEG7_ALT_GLYPH_EN
    if (g == 7'b0011111) return 5'h06;
    if (g == 7'b1110011) return 5'h09;
    if (g == 7'b1110010) return 5'h07;
`endif
    if (g == 7'b0000000) return 5'h0F;
    return 5'h1E;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [ND-1:0] s, input logic [6:0] l);
    logic [4:0] d;
    rst = r; sel = s; led = l;
    @(posedge clk);
    m_fv = 1'b0;
    m_fe = 1'b0;
    if (r) begin
      m_bcd = {ND{4'hF}}; m_err = '0; m_map = '0; run = 0;
    end else begin
      if (run > 0 && s == m_last_sel && l == m_last_led) run++;
      else run = 1;
      m_last_sel = s;
      m_last_led = l;
      if ($countones(s) == 1 && run == int'(SC) + 1) begin
        d = ref_decode(l);
        for (int n = 0; n < int'(ND); n++) begin
          if (s[n]) begin
            m_bcd[4*n +: 4] = d[3:0];
            m_err[n] = d[4];
            m_map[n] = 1'b1;
          end
        end
        if (&m_map) begin
          m_fv = 1'b1;
          m_fe = |m_err;
          m_map = '0;
        end
      end
    end
    #1;
    check("bcd", 64'(bcd), 64'(m_bcd));
    check("digit_err", 64'(digit_err), 64'(m_err));
    check("frame_valid", 64'(frame_valid), 64'(m_fv));
    check("frame_err", 64'(frame_err), 64'(m_fe));
    edge_in_seg++;
    if (frame_valid) begin
      pulses++;
      pulse_at = edge_in_seg;
      last_fe = frame_err;
    end
  endtask

  task automatic hold(input logic [ND-1:0] s, input logic [6:0] l, input int n);
    for (int i = 0; i < n; i++) step(1'b0, s, l);
  endtask

  initial begin
    logic [3:0] dig [ND];
    logic [6:0] g;
    logic [ND-1:0] s;
    int cap_at, len;

    pulses = 0; pulse_at = 0; edge_in_seg = 0; last_fe = 1'b0;
    m_last_sel = '0; m_last_led = '0;

    // Reset and idle
    step(1'b1, '0, '0);
    step(1'b1, '0, '0);
    check("reset_bcd", 64'(bcd), 64'h00FF_FFFF);
    check("reset_err", 64'(digit_err), 64'h0);
    check("reset_fv", 64'(frame_valid), 64'h0);
    pulses = 0;
    hold('0, '0, 100);
    check("idle_pulses", 64'(pulses), 64'h0);
    check("idle_bcd", 64'(bcd), 64'h00FF_FFFF);

    // Clean scan: 1,2,3,4,5,9
    dig = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
    pulses = 0;
    for (int d = 0; d < 5; d++) hold(ND'(1) << d, GLYPH[dig[d]], 8);
    edge_in_seg = 0;
    hold(ND'(1) << 5, GLYPH[dig[5]], 8);
    check("scan_pulses", 64'(pulses), 64'h1);
    check("scan_pulse_edge", 64'(pulse_at), 64'h5);
    check("scan_frame_err", 64'(last_fe), 64'h0);
    check("scan_bcd", 64'(bcd), 64'h0095_4321);

    // Glitch restarts the stability count
    hold(6'b000100, 7'b1011011, 3);
    check("glitch_no_early", 64'(bcd[11:8]), 64'h3);
    hold(6'b000100, 7'b0000001, 1);
    check("glitch_no_cap", 64'(bcd[11:8]), 64'h3);
    cap_at = 0;
    for (int i = 1; i <= 6; i++) begin
      step(1'b0, 6'b000100, 7'b1011011);
      if (cap_at == 0 && bcd[11:8] == 4'd5) cap_at = i;
    end
    check("glitch_cap_edge", 64'(cap_at), 64'h5);

    // Two selects active: nothing captured
    pulses = 0;
    hold(6'b000011, GLYPH[8], 20);
    check("twohot_bcd", 64'(bcd), 64'h0095_4521);
    check("twohot_pulses", 64'(pulses), 64'h0);

    // Frame containing a bad glyph on digit 4
    pulses = 0;
    for (int d = 0; d < 6; d++) hold(ND'(1) << d, (d == 4) ? 7'b1000000 : GLYPH[d], 8);
    check("bad_pulses", 64'(pulses), 64'h1);
    check("bad_frame_err", 64'(last_fe), 64'h1);
    check("bad_digit", 64'(bcd[19:16]), 64'hE);
    check("bad_err_bit", 64'(digit_err[4]), 64'h1);

    // Following clean frame clears the error
    pulses = 0;
    for (int d = 0; d < 6; d++) hold(ND'(1) << d, GLYPH[d], 8);
    check("clean_pulses", 64'(pulses), 64'h1);
    check("clean_frame_err", 64'(last_fe), 64'h0);
    check("clean_err", 64'(digit_err), 64'h0);
    check("clean_bcd", 64'(bcd), 64'h0054_3210);

    // Alternate 6 glyph
    hold(6'b000001, 7'b0011111, 8);
`ifdef SEG7_ALT_GLYPH_EN
    check("alt6_bcd", 64'(bcd[3:0]), 64'h6);
    check("alt6_err", 64'(digit_err[0]), 64'h0);
`else
    check("alt6_bcd", 64'(bcd[3:0]), 64'hE);
    check("alt6_err", 64'(digit_err[0]), 64'h1);
`endif

    // Random dwell sequences, with occasional mid-frame reset
    for (int seg = 0; seg < 350; seg++) begin
      if ($urandom_range(0, 99) < 2) begin
        step(1'b1, '0, '0);
      end else begin
        if ($urandom_range(0, 9) < 8) s = ND'(1) << $urandom_range(0, ND - 1);
        else s = ND'($urandom_range(0, (1 << ND) - 1));
        case ($urandom_range(0, 19)) inside
          [0:11]:  g = GLYPH[$urandom_range(0, 9)];
          [12:14]: g = 7'b0000000;
          default: g = 7'($urandom_range(0, 127));
        endcase
        len = int'($urandom_range(1, 7));
        hold(s, g, len);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
